rx_uart: RTL

UART receiver, the far-end counterpart of the team's TX_UART transmitter.
- Format: 8N1, LSB first, idle-high line, oversampled by the system clock.
- Timing matches the transmitter exactly.
- Data is delivered through a single holding register with a valid/ready handshake.
- Flow control: rts_o feeds the remote transmitter's cts_i; high means "may send".

---
 rtl/rx_uart.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/rx_uart.sv
// UART receiver (8N1, LSB first, idle-high). Single holding register with valid/ready.
// Optional parity state is compiled in with `define RX_UART_PARITY_EN (parameter PARITY_ODD).
module rx_uart #(
    parameter int FREQUENCY = 130,
    parameter int BAUDRATE  = 9600
`ifdef RX_UART_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_vld_o,
    input  logic       rx_rdy_i,
    output logic       rts_o,
    output logic       rx_ferr_o,
    output logic       rx_ovr_o,
    output logic       rx_perr_o
);

    localparam logic [31:0] PERIOD = 32'((FREQUENCY * 1000000) / BAUDRATE);
    localparam logic [31:0] HALF   = PERIOD >> 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_BIT    = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t      r_state;
    logic [1:0]  r_sync;
    logic        r_prev;
    logic [31:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;
    logic        r_done;
    logic        r_stop_ok;
    logic [7:0]  r_data;
    logic        r_vld;
    logic        r_rts;
    logic        r_ferr;
    logic        r_ovr;
    logic        r_perr;
    logic        w_rx_s;
    logic        w_fall;
    logic        w_par_bad;
    logic        w_good;

`ifdef RX_UART_PARITY_EN
    logic        r_par_bad;

    // True when the received parity bit disagrees with the configured sense.
    function automatic logic f_parity_bad(input logic [7:0] d, input logic p, input logic odd);
        return ((^d) ^ p) != odd;
    endfunction

    assign w_par_bad = r_par_bad;
`else
    assign w_par_bad = 1'b0;
`endif

    assign w_rx_s  = r_sync[1];
    assign w_fall  = r_prev & ~w_rx_s;
    assign w_good  = r_done & r_stop_ok & ~w_par_bad;

    assign rx_data_o = r_data;
    assign rx_vld_o  = r_vld;
    assign rts_o     = r_rts;
    assign rx_ferr_o = r_ferr;
    assign rx_ovr_o  = r_ovr;
    assign rx_perr_o = r_perr;

    // Synchroniser, receive FSM and holding-register delivery.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= 2'b11;
            r_prev    <= 1'b1;
            r_state   <= S_IDLE;
            r_cnt     <= 32'd0;
            r_idx     <= 3'd0;
            r_shift   <= 8'd0;
            r_done    <= 1'b0;
            r_stop_ok <= 1'b0;
            r_data    <= 8'd0;
            r_vld     <= 1'b0;
            r_rts     <= 1'b1;
            r_ferr    <= 1'b0;
            r_ovr     <= 1'b0;
            r_perr    <= 1'b0;
`ifdef RX_UART_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            r_sync <= {r_sync[0], rx_i};
            r_prev <= w_rx_s;
            r_done <= 1'b0;

            // Delivery happens one clock after the stop sample; a consumer
            // handshake in the same cycle frees room for the new byte.
            if (w_good && (!r_vld || rx_rdy_i)) begin
                r_data <= r_shift;
                r_vld  <= 1'b1;
                r_rts  <= 1'b0;
            end else if (r_vld && rx_rdy_i) begin
                r_vld  <= 1'b0;
                r_rts  <= 1'b1;
            end else begin
                r_vld  <= r_vld;
            end
            r_ferr <= r_done & ~r_stop_ok;
            r_perr <= r_done & w_par_bad;
            r_ovr  <= w_good & r_vld & ~rx_rdy_i;

            case (r_state)
                S_IDLE: begin
                    r_cnt <= 32'd0;
                    if (w_fall) begin
                        r_state <= S_START;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_START: begin
                    if (r_cnt == HALF) begin
                        r_cnt <= 32'd0;
                        r_idx <= 3'd0;
                        r_state <= w_rx_s ? S_IDLE : S_BIT;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_BIT: begin
                    if (r_cnt == PERIOD) begin
                        r_cnt          <= 32'd0;
                        r_shift[r_idx] <= w_rx_s;
                        r_idx          <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
`ifdef RX_UART_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_state <= S_BIT;
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
`ifdef RX_UART_PARITY_EN
                S_PARITY: begin
                    if (r_cnt == PERIOD) begin
                        r_cnt     <= 32'd0;
                        r_par_bad <= f_parity_bad(r_shift, w_rx_s, PARITY_ODD);
                        r_state   <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
`endif
                S_STOP: begin
                    // Leave mid-stop-bit so the next start edge is not missed.
                    if (r_cnt == PERIOD) begin
                        r_cnt     <= 32'd0;
                        r_stop_ok <= w_rx_s;
                        r_done    <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: begin
                    r_cnt   <= 32'd0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
